slave_mem_ctrl: RTL

- Memory-side stage directly downstream of the bus slave port.
- Consumes the decoded request: address, write data, read/write enables, burst length and rx-done strobe.
- Performs single or burst writes/reads into a local byte-wide memory, applying the programmed slave read delay.
- Presents read bytes to the slave port's transmit side with a valid/ack handshake.

---
 rtl/slave_mem_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/slave_mem_ctrl.sv
// Byte-memory stage behind the bus slave port: single/burst writes, delayed single/burst reads.
// Read latency 2+slave_delay cycles to first byte, later burst beats back-to-back; rd_data held until rd_ack.
module slave_mem_ctrl #(
    parameter int ADDR_WIDTH     = 11,
    parameter int DATA_WIDTH     = 8,
    parameter int BUS_ADDR_WIDTH = 12,
    parameter int DELAY_WIDTH    = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    input  logic                      req_write,
    input  logic                      req_read,
    input  logic [BUS_ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [BUS_ADDR_WIDTH-1:0] burst_len,
    input  logic [DELAY_WIDTH-1:0]    slave_delay,
    input  logic                      rd_ack,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      busy,
    output logic [BUS_ADDR_WIDTH-1:0] beat_count,
    output logic                      addr_err
);

    localparam int DCNT_W = DELAY_WIDTH + 1;
    localparam logic [BUS_ADDR_WIDTH-1:0] ONE      = 1;
    localparam logic [DCNT_W-1:0]         DCNT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_WAIT,
        RD_PRESENT
    } state_t;

    state_t                    state, state_nxt;
    logic [BUS_ADDR_WIDTH-1:0] ptr, ptr_nxt;
    logic [BUS_ADDR_WIDTH-1:0] remaining, remaining_nxt;
    logic [BUS_ADDR_WIDTH-1:0] beat_count_nxt;
    logic [DCNT_W-1:0]         dcnt, dcnt_nxt;
    logic [DATA_WIDTH-1:0]     rd_data_nxt;
    logic                      rd_valid_nxt;
    logic                      addr_err_nxt;
    logic [BUS_ADDR_WIDTH-1:0] ptr_inc;

    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_waddr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH-1:0]     mem [2**ADDR_WIDTH];

    function automatic logic in_range(input logic [BUS_ADDR_WIDTH-1:0] a);
        return (a >> ADDR_WIDTH) == '0;
    endfunction

    assign ptr_inc = ptr + ONE;
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        remaining_nxt  = remaining;
        dcnt_nxt       = dcnt;
        beat_count_nxt = beat_count;
        rd_data_nxt    = rd_data;
        rd_valid_nxt   = rd_valid;
        addr_err_nxt   = 1'b0;
        mem_we         = 1'b0;
        mem_waddr      = ptr[ADDR_WIDTH-1:0];
        mem_wdata      = req_wdata;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_write && !req_read) begin
                        beat_count_nxt = ONE;
                        mem_waddr      = req_addr[ADDR_WIDTH-1:0];
                        if (in_range(req_addr)) mem_we = 1'b1;
                        else                    addr_err_nxt = 1'b1;
                        if (burst_len != '0) begin
                            ptr_nxt       = req_addr + ONE;
                            remaining_nxt = burst_len;
                            state_nxt     = WR_BURST;
                        end
                    end else if (req_read && !req_write) begin
                        ptr_nxt        = req_addr;
                        remaining_nxt  = burst_len;
                        // One extra count covers the RAM access stage ahead of rd_data.
                        dcnt_nxt       = DCNT_W'(slave_delay) + DCNT_ONE;
                        beat_count_nxt = '0;
                        state_nxt      = RD_WAIT;
                    end else begin
                        addr_err_nxt = 1'b1;
                    end
                end
            end

            WR_BURST: begin
                if (req_valid) begin
                    if (req_write && !req_read) begin
                        if (in_range(ptr)) mem_we = 1'b1;
                        else               addr_err_nxt = 1'b1;
                        ptr_nxt        = ptr_inc;
                        remaining_nxt  = remaining - ONE;
                        beat_count_nxt = beat_count + ONE;
                        if (remaining == ONE) state_nxt = IDLE;
                    end else begin
                        addr_err_nxt = 1'b1;
                    end
                end
            end

            RD_WAIT: begin
                if (req_valid) addr_err_nxt = 1'b1;
                if (dcnt != '0) begin
                    dcnt_nxt = dcnt - DCNT_ONE;
                end else begin
                    rd_valid_nxt = 1'b1;
                    state_nxt    = RD_PRESENT;
                    if (in_range(ptr)) begin
                        rd_data_nxt = mem[ptr[ADDR_WIDTH-1:0]];
                    end else begin
                        rd_data_nxt  = '0;
                        addr_err_nxt = 1'b1;
                    end
                end
            end

            RD_PRESENT: begin
                if (req_valid) addr_err_nxt = 1'b1;
                if (rd_ack) begin
                    beat_count_nxt = beat_count + ONE;
                    if (remaining == '0) begin
                        rd_valid_nxt = 1'b0;
                        state_nxt    = IDLE;
                    end else begin
                        ptr_nxt       = ptr_inc;
                        remaining_nxt = remaining - ONE;
                        if (in_range(ptr_inc)) begin
                            rd_data_nxt = mem[ptr_inc[ADDR_WIDTH-1:0]];
                        end else begin
                            rd_data_nxt  = '0;
                            addr_err_nxt = 1'b1;
                        end
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            remaining  <= '0;
            dcnt       <= '0;
            beat_count <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            remaining  <= remaining_nxt;
            dcnt       <= dcnt_nxt;
            beat_count <= beat_count_nxt;
            rd_data    <= rd_data_nxt;
            rd_valid   <= rd_valid_nxt;
            addr_err   <= addr_err_nxt;
        end
    end

    // Storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

endmodule
